// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if
//   Bundles the multiply handshake, the core-side ALU request path and the
//   addsub-side ALU connection of mul_seq_ctrl.
//   slave  : the sequencer (drives busy/done/product, cpu_grant, alu_op1/op2/ctrl)
//   master : core + addsub side (drives start/mcand/mplr, cpu_op1/op2/ctrl, alu_out)
// Ports (signals)
//   start, mcand, mplr     multiply request and operands
//   busy, done, product    sequencer status and result
//   cpu_op1/op2/ctrl       core ALU request
//   cpu_grant              1 = core owns the ALU
//   alu_op1/op2/ctrl       to addsub
//   alu_out                from addsub
interface mul_seq_ctrl_if #(
  parameter int L_DATA = 16
);
  logic              start;
  logic [L_DATA-1:0] mcand;
  logic [L_DATA-1:0] mplr;
  logic              busy;
  logic              done;
  logic [L_DATA-1:0] product;
  logic [L_DATA-1:0] cpu_op1;
  logic [L_DATA-1:0] cpu_op2;
  logic [2:0]        cpu_ctrl;
  logic              cpu_grant;
  logic [L_DATA-1:0] alu_op1;
  logic [L_DATA-1:0] alu_op2;
  logic [2:0]        alu_ctrl;
  logic [L_DATA-1:0] alu_out;

  modport master (
    output start, mcand, mplr, cpu_op1, cpu_op2, cpu_ctrl, alu_out,
    input  busy, done, product, cpu_grant, alu_op1, alu_op2, alu_ctrl
  );

  modport slave (
    input  start, mcand, mplr, cpu_op1, cpu_op2, cpu_ctrl, alu_out,
    output busy, done, product, cpu_grant, alu_op1, alu_op2, alu_ctrl
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Shift-add multiply sequencer that borrows the shared addsub ALU for its
//   additions. While idle the core's ALU request passes straight through;
//   while a multiply runs the sequencer drives the ALU with acc + M.
//   Product is the low L_DATA bits of the unsigned product.
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   mul_seq_ctrl_if.slave (handshake, core ALU path, addsub path)
// Configuration
//   MUL_EARLY_EXIT_EN  when defined, RUN ends as soon as no multiplier bits
//                      remain; results are identical, only latency shrinks.
//
// state | meaning
// IDLE  | core owns the ALU, waiting for start
// RUN   | one shift-add iteration per cycle, sequencer owns the ALU
// DONE  | one-cycle done pulse, product valid
module mul_seq_ctrl #(
  parameter int L_DATA = 16,
  parameter int L_CNT  = 5
) (
  input logic           clk,
  input logic           rst,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [L_CNT-1:0] CNT_LAST = L_CNT'(L_DATA - 1);

  state_t            state;
  logic [L_DATA-1:0] acc;
  logic [L_DATA-1:0] m;
  logic [L_DATA-1:0] q;
  logic [L_CNT-1:0]  cnt;
  logic [L_DATA-1:0] product;
  logic              busy;
  logic              done;
  logic [L_DATA-1:0] acc_next;
  logic              last;

  // The ALU sees acc + M during RUN, so its output is the accumulated sum.
  assign acc_next = q[0] ? bus.alu_out : acc;

`ifdef MUL_EARLY_EXIT_EN
  assign last = (cnt == CNT_LAST) || ((q >> 1) == '0);
`else
  assign last = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m     <= bus.mcand;
            q     <= bus.mplr;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + L_CNT'(1);
          if (last) begin
            product <= acc_next;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.product   = product;
  assign bus.cpu_grant = (state != RUN);

  always_comb begin
    bus.alu_op1  = bus.cpu_op1;
    bus.alu_op2  = bus.cpu_op2;
    bus.alu_ctrl = bus.cpu_ctrl;
    if (state == RUN) begin
      bus.alu_op1  = acc;
      bus.alu_op2  = m;
      bus.alu_ctrl = 3'b000;
    end
  end

endmodule
